// File: rtl/neo_pixel_decoder.sv
// NeoPixel (WS2812-style) one-wire receiver: decodes the serial stream into indexed 24-bit {G,R,B} words.
// Optional: define NEO_RX_GLITCH_FILTER_EN to drop high pulses shorter than MIN_HIGH.
`timescale 1ns/1ps
module neo_pixel_decoder #(
    parameter int NUM_PIXELS = 5,
    parameter int BIT_THRESH = 26,
    parameter int MAX_HIGH   = 50,
    parameter int MIN_HIGH   = 8,
    parameter int RESET_LOW  = 2500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        neo_in,
    output logic [23:0] pixel_data,
    output logic [2:0]  pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [3:0]  pixel_count,
    output logic        error
);

    localparam logic [1:0] ST_WAIT_GAP = 2'd0;
    localparam logic [1:0] ST_READY    = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_LOW      = 2'd3;

    // High counter must hold both its saturation value and the glitch threshold it is compared to.
    localparam int HC_TOP = (MAX_HIGH + 1 > MIN_HIGH) ? MAX_HIGH + 1 : MIN_HIGH;
    localparam int HC_W   = $clog2(HC_TOP + 1);
    localparam int LC_W   = $clog2(RESET_LOW + 1);

    logic             sync1_q, s_in_q, s_prev_q;
    logic [1:0]       state_q, state_d;
    logic [HC_W-1:0]  high_q, high_d;
    logic [LC_W-1:0]  low_q, low_d;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_q, bit_d;
    logic [3:0]       pix_q, pix_d;
    logic [23:0]      pixel_data_q, pixel_data_d;
    logic [2:0]       pixel_index_q, pixel_index_d;
    logic [3:0]       pixel_count_q, pixel_count_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             error_q, error_d;
    logic             rise, fall, bit_val, glitch;

    assign rise = s_in_q & ~s_prev_q;
    assign fall = ~s_in_q & s_prev_q;

    always_comb begin
        state_d       = state_q;
        high_d        = high_q;
        low_d         = low_q;
        shift_d       = shift_q;
        bit_d         = bit_q;
        pix_d         = pix_q;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        pixel_count_d = pixel_count_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        error_d       = 1'b0;
        bit_val       = 1'b0;
        glitch        = 1'b0;
        case (state_q)
            ST_WAIT_GAP: begin
                if (s_in_q) begin
                    low_d = '0;
                end else if (low_q >= LC_W'(RESET_LOW - 1)) begin
                    low_d   = LC_W'(RESET_LOW);
                    state_d = ST_READY;
                end else begin
                    low_d = low_q + 1'b1;
                end
            end
            ST_READY: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    high_d  = HC_W'(1);
                end
            end
            ST_HIGH: begin
                if (high_q > HC_W'(MAX_HIGH)) begin
                    // Overlong pulse: abandon the frame and resynchronise on the next gap.
                    error_d = 1'b1;
                    state_d = ST_WAIT_GAP;
                    low_d   = '0;
                    bit_d   = '0;
                    pix_d   = '0;
                end else if (fall) begin
`ifdef NEO_RX_GLITCH_FILTER_EN
                    glitch = (high_q < HC_W'(MIN_HIGH));
`endif
                    state_d = ST_LOW;
                    low_d   = LC_W'(1);
                    if (!glitch) begin
                        bit_val = (high_q >= HC_W'(BIT_THRESH));
                        shift_d = {shift_q[22:0], bit_val};
                        if (bit_q == 5'd23) begin
                            bit_d = '0;
                            if (pix_q < 4'(NUM_PIXELS)) begin
                                pixel_data_d  = {shift_q[22:0], bit_val};
                                pixel_index_d = pix_q[2:0];
                                pixel_valid_d = 1'b1;
                                pix_d         = pix_q + 4'd1;
                            end else begin
                                error_d = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end else begin
                    high_d = high_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    high_d  = HC_W'(1);
                end else if (low_q >= LC_W'(RESET_LOW - 1)) begin
                    low_d         = LC_W'(RESET_LOW);
                    state_d       = ST_READY;
                    frame_done_d  = 1'b1;
                    pixel_count_d = pix_q;
                    error_d       = (bit_q != 5'd0);
                    bit_d         = '0;
                    pix_d         = '0;
                end else begin
                    low_d = low_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT_GAP;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b0;
            s_in_q        <= 1'b0;
            s_prev_q      <= 1'b0;
            state_q       <= ST_WAIT_GAP;
            high_q        <= '0;
            low_q         <= '0;
            shift_q       <= '0;
            bit_q         <= '0;
            pix_q         <= '0;
            pixel_data_q  <= '0;
            pixel_index_q <= '0;
            pixel_count_q <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            sync1_q       <= neo_in;
            s_in_q        <= sync1_q;
            s_prev_q      <= s_in_q;
            state_q       <= state_d;
            high_q        <= high_d;
            low_q         <= low_d;
            shift_q       <= shift_d;
            bit_q         <= bit_d;
            pix_q         <= pix_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            pixel_count_q <= pixel_count_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_index = pixel_index_q;
    assign pixel_count = pixel_count_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_neo_pixel_decoder.sv
// Scoreboard bench for neo_pixel_decoder: line segments feed a frame-level model, a monitor checks DUT strobes.
`timescale 1ns/1ps
module tb_neo_pixel_decoder;

    localparam int NUM_PIXELS = 5;
    localparam int BIT_THRESH = 26;
    localparam int MAX_HIGH   = 50;
    localparam int MIN_HIGH   = 8;
    localparam int RESET_LOW  = 2500;
    localparam int GAP        = 2550;

    localparam logic [1:0] K_PIX   = 2'd0;
    localparam logic [1:0] K_FRAME = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        neo_in = 1'b0;
    logic [23:0] pixel_data;
    logic [2:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [3:0]  pixel_count;
    logic        error;

    neo_pixel_decoder #(
        .NUM_PIXELS(NUM_PIXELS), .BIT_THRESH(BIT_THRESH), .MAX_HIGH(MAX_HIGH),
        .MIN_HIGH(MIN_HIGH), .RESET_LOW(RESET_LOW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .neo_in(neo_in),
        .pixel_data(pixel_data), .pixel_index(pixel_index), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .pixel_count(pixel_count), .error(error)
    );

    always #10 clock = ~clock;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] data;
        logic [2:0]  idx;
        logic [3:0]  cnt;
        logic        err;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Frame-level reference model state
    bit          m_synced;
    bit          m_inframe;
    int          m_bits;
    int          m_pix;
    logic [23:0] m_shift;
    logic [23:0] last_data;
    logic [2:0]  last_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic [23:0] d, input int i, input int c, input logic e);
        ev_t ev;
        ev.kind = k; ev.data = d; ev.idx = 3'(i); ev.cnt = 4'(c); ev.err = e;
        return ev;
    endfunction

    task automatic model_reset();
        m_synced = 0; m_inframe = 0; m_bits = 0; m_pix = 0; m_shift = '0;
    endtask

    task automatic model_high(input int dur);
        if (!m_synced) return;
        if (dur > MAX_HIGH) begin
            exp_q.push_back(mk(K_ERR, 24'h0, 0, 0, 1'b1));
            model_reset();
            return;
        end
        m_inframe = 1;
`ifdef NEO_RX_GLITCH_FILTER_EN
        if (dur < MIN_HIGH) return;
`endif
        m_shift = {m_shift[22:0], (dur >= BIT_THRESH) ? 1'b1 : 1'b0};
        m_bits++;
        if (m_bits == 24) begin
            m_bits = 0;
            if (m_pix < NUM_PIXELS) begin
                exp_q.push_back(mk(K_PIX, m_shift, m_pix, 0, 1'b0));
                m_pix++;
            end else begin
                exp_q.push_back(mk(K_ERR, 24'h0, 0, 0, 1'b1));
            end
        end
    endtask

    task automatic model_low(input int dur);
        if (dur < RESET_LOW) return;
        if (m_synced && m_inframe)
            exp_q.push_back(mk(K_FRAME, 24'h0, 0, m_pix, (m_bits != 0)));
        m_synced = 1; m_inframe = 0; m_bits = 0; m_pix = 0;
    endtask

    task automatic seg(input logic lvl, input int dur);
        if (lvl) model_high(dur); else model_low(dur);
        neo_in = lvl;
        repeat (dur) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        seg(1'b1, b ? 35 : 18);
        seg(1'b0, b ? 27 : 44);
    endtask

    task automatic send_rand_bit(input logic b);
        seg(1'b1, b ? int'($urandom_range(30, 45)) : int'($urandom_range(10, 22)));
        seg(1'b0, int'($urandom_range(8, 20)));
    endtask

    task automatic send_pixel(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic gap();
        seg(1'b0, GAP);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        neo_in = 1'b0;
        reset_n = 1'b0;
        model_reset();
        exp_q.delete();
        last_data = '0;
        last_idx = '0;
        repeat (3) @(negedge clock);
        check("rst_pixel_data", pixel_data, 0);
        check("rst_pixel_index", pixel_index, 0);
        check("rst_pixel_count", pixel_count, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_error", error, 0);
        reset_n = 1'b1;
    endtask

    // Monitor: every strobe must match the next expected event in order
    always @(negedge clock) begin
        if (reset_n && (pixel_valid || frame_done || error)) begin
            ev_t e;
            logic [1:0] akind;
            akind = frame_done ? K_FRAME : (pixel_valid ? K_PIX : K_ERR);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d (valid=%0d done=%0d err=%0d) expected none at %0t",
                         akind, pixel_valid, frame_done, error, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", akind, e.kind);
                if (e.kind == K_PIX) begin
                    check("pixel_data", pixel_data, e.data);
                    check("pixel_index", pixel_index, e.idx);
                    check("pix_error", error, 0);
                    last_data = e.data;
                    last_idx  = e.idx;
                end else if (e.kind == K_FRAME) begin
                    check("pixel_count", pixel_count, e.cnt);
                    check("frame_error", error, e.err);
                    check("valid_with_done", pixel_valid, 0);
                    check("hold_data", pixel_data, last_data);
                    check("hold_index", pixel_index, last_idx);
                end
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clock);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] w;
        int npix, extra;

        // Nominal frame after a startup gap
        do_reset();
        gap();
        send_pixel(24'h00FF00);
        send_pixel(24'h112233);
        send_pixel(24'hFFFFFF);
        send_pixel(24'h000000);
        send_pixel(24'h800001);
        gap();
        drain("drain_nominal");

        // Line starts high: nothing decodes until the first full gap
        do_reset();
        send_pixel(24'hA5A5A5);
        send_pixel(24'h5A5A5A);
        send_pixel(24'h123456);
        gap();
        send_pixel(24'hC3_0F_81);
        gap();
        drain("drain_unsynced_start");

        // Overflow: six pixels
        gap();
        send_pixel(24'h010203);
        send_pixel(24'h040506);
        send_pixel(24'h070809);
        send_pixel(24'h0A0B0C);
        send_pixel(24'h0D0E0F);
        send_pixel(24'hDEADBE);
        gap();
        drain("drain_overflow");

        // Partial pixel: 12 bits then gap
        w = 24'hABC000;
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        gap();
        drain("drain_partial");

        // Overlong high mid-pixel, then recovery
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        seg(1'b1, 60);
        seg(1'b0, 30);
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        gap();
        send_pixel(24'h7E57ED);
        send_pixel(24'h00C0DE);
        gap();
        drain("drain_long_high");

        // Short glitch between bits
        w = 24'h96E1F0;
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == 17) begin
                seg(1'b1, 4);
                seg(1'b0, 20);
            end
        end
        send_pixel(24'h3C3C3C);
        gap();
        drain("drain_glitch");

        // Randomized frames with random timing and optional trailing partial pixel
        for (int f = 0; f < 3; f++) begin
            npix  = int'($urandom_range(0, 4));
            extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 23)) : 0;
            if (npix == 0 && extra == 0) extra = 5;
            for (int p = 0; p < npix; p++) begin
                w = 24'($urandom);
                for (int i = 23; i >= 0; i--) send_rand_bit(w[i]);
            end
            for (int i = 0; i < extra; i++) send_rand_bit(1'($urandom));
            gap();
            drain("drain_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neo_pixel_decoder.md
# neo_pixel_decoder

Receives the one-wire NeoPixel (WS2812-style) serial stream produced by the strand controller and decodes it back into 24-bit pixel words, indexed by position in the strand. Sits on the board beside the strand controller, sampling the same GPIO data line or a loopback pin, and gives the team an in-system monitor and loopback checker for the transmit path. Runs at the 50 MHz board clock.

## Interface
- NUM_PIXELS, 5: pixels per strand; words beyond this are flagged, not emitted
- BIT_THRESH, 26: high-pulse length in cycles at or above which a bit decodes as 1
- MAX_HIGH, 50: high-pulse length in cycles beyond which the pulse is an error
- MIN_HIGH, 8: shortest accepted high pulse in cycles (glitch filter only)
- RESET_LOW, 2500: low time in cycles that marks a frame latch (50 us)

- clock  input  1  system clock, 50 MHz, rising edge
- reset_n  input  1  asynchronous, active-low reset
- neo_in  input  1  raw serial data line, asynchronous to clock
- pixel_data  output  24  last decoded pixel, {G,R,B}, first bit received = bit 23
- pixel_index  output  3  strand position of pixel_data, 0-based
- pixel_valid  output  1  one-cycle strobe: pixel_data/pixel_index updated
- frame_done  output  1  one-cycle strobe: latch gap detected after at least one bit
- pixel_count  output  4  pixels decoded in the frame just ended; valid with frame_done
- error  output  1  one-cycle strobe on any protocol violation

## Operation
- neo_in passes through a two-flop synchronizer; all decoding uses the synchronized value s_in and its previous value for edge detection.
- States: WAIT_GAP, READY, HIGH, LOW.
- WAIT_GAP (reset state): low counter counts while s_in = 0 and clears when s_in = 1. Reaching RESET_LOW -> READY, with no frame_done.
- READY: rising edge -> HIGH, high counter = 1.
- HIGH: high counter increments. Falling edge -> classify the bit (count >= BIT_THRESH gives 1, otherwise 0), shift it in MSB-first, increment bit_cnt (0..23), clear the low counter, -> LOW. Count exceeding MAX_HIGH -> error, discard the partial pixel, -> WAIT_GAP.
- LOW: rising edge -> HIGH. Low counter reaching RESET_LOW -> end of frame, -> READY.
- When bit_cnt wraps 23 -> 0:
  - If the pixel count is below NUM_PIXELS: load pixel_data, set pixel_index to the count, strobe pixel_valid, increment the count.
  - Otherwise: strobe error, do not emit; the count saturates at NUM_PIXELS.
- End of frame:
  - Strobe frame_done with pixel_count = pixels emitted.
  - bit_cnt != 0 at this point also strobes error in the same cycle; the partial pixel is discarded.
  - Clear bit_cnt and the internal pixel counter.
- Counters saturate: high at MAX_HIGH+1, low at RESET_LOW. No wrap.
- pixel_data and pixel_index hold between strobes.

## Timing
- Reset values:
  - pixel_data = 0, pixel_index = 0, pixel_count = 0.
  - pixel_valid = 0, frame_done = 0, error = 0.
  - State WAIT_GAP, all counters 0. Reset mid-frame abandons the frame immediately.
- Edge latency: a neo_in transition is seen as an s_in edge 2 cycles later. pixel_valid asserts in the cycle after the synchronized falling edge of bit 24, so 3 cycles after neo_in falls.
- frame_done asserts on the cycle the low counter reaches RESET_LOW, counted from the first synchronized low cycle.
- High length is measured in synchronized cycles. A nominal 0 bit (18 cycles) and 1 bit (35 cycles) decode unambiguously.
- All strobes are exactly one cycle wide. pixel_valid and frame_done never coincide: the gap follows the last falling edge by at least RESET_LOW cycles.

## Configuration
- NEO_RX_GLITCH_FILTER_EN defined:
  - A falling edge with high count < MIN_HIGH is discarded: no bit, bit_cnt unchanged, no error.
  - Returns to LOW with the low counter cleared.
- Undefined: any high pulse of 1 or more cycles decodes as a bit (a 0 bit); MIN_HIGH is unused.

## Test plan
- Reset released, line low 2500 cycles, then 5 pixels of 0x00FF00, 0x112233, 0xFFFFFF, 0x000000, 0x800001 at nominal timing, then 50 us low -> five pixel_valid strobes with matching data and indices 0..4, then frame_done with pixel_count = 5, no error.
- Same stimulus without the leading 2500-cycle gap, starting high after reset -> nothing decoded until the first full gap; no frame_done for the startup gap.
- 6 pixels sent -> indices 0..4 emitted; error strobe at the 6th pixel; frame_done with pixel_count = 5.
- 12 bits then gap -> no pixel_valid; frame_done with pixel_count = 0 and error in the same cycle.
- High held 60 cycles mid-pixel -> error; WAIT_GAP; the next full frame decodes correctly.
- 4-cycle high glitch between bits -> with the macro, ignored and data intact; without it, an extra 0 bit shifts the data and a partial-pixel error appears at frame end.
